// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - memory-mapped GPIO bank with direction, atomic set/clear and edge interrupts
module gpio_bank #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
    parameter int          WIDTH       = 32,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      address,
    input  logic [31:0]      wdata,
    input  logic [3:0]       byte_en,
    input  logic             memwrite,
    input  logic             memread,
    output logic [31:0]      rdata,
    output logic             hit,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] OFF_OUT    = 3'd0;
    localparam logic [2:0] OFF_DIR    = 3'd1;
    localparam logic [2:0] OFF_IN     = 3'd2;
    localparam logic [2:0] OFF_IE     = 3'd3;
    localparam logic [2:0] OFF_EDGE   = 3'd4;
    localparam logic [2:0] OFF_STATUS = 3'd5;
    localparam logic [2:0] OFF_SET    = 3'd6;
    localparam logic [2:0] OFF_CLR    = 3'd7;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] ie_q;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] in_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

    logic [2:0]       offset;
    logic             wr_en;
    logic [31:0]      lane_mask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wbits;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] status_clr;
    logic [WIDTH-1:0] rsel;
    logic             unused_addr_bits;

    assign hit              = (address[31:5] == BASE_ADDR[31:5]);
    assign offset           = address[4:2];
    assign unused_addr_bits = ^address[1:0];
    assign wr_en            = hit & memwrite;

    // Byte lanes expanded to bit mask, then cut to the implemented pins.
    assign lane_mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
    assign wmask     = lane_mask[WIDTH-1:0];
    assign wbits     = wdata[WIDTH-1:0] & wmask;

    assign in_q = sync_q[SYNC_STAGES-1];
    assign evt  = ((edge_q & ~in_q & prev_q) | (~edge_q & in_q & ~prev_q)) & ie_q;

    assign status_clr = (wr_en && offset == OFF_STATUS) ? wbits : '0;

    always_comb begin
        merged = '0;
        case (offset)
            OFF_OUT:  merged = (out_q  & ~wmask) | wbits;
            OFF_DIR:  merged = (dir_q  & ~wmask) | wbits;
            OFF_IE:   merged = (ie_q   & ~wmask) | wbits;
            OFF_EDGE: merged = (edge_q & ~wmask) | wbits;
            default:  merged = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q    <= '0;
            dir_q    <= '0;
            ie_q     <= '0;
            edge_q   <= '0;
            status_q <= '0;
            prev_q   <= '0;
            sync_q   <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= in_q;
            // New events are OR-ed after the clear so a same-cycle event survives.
            status_q <= (status_q & ~status_clr) | evt;
            if (wr_en) begin
                case (offset)
                    OFF_OUT:  out_q  <= merged;
                    OFF_DIR:  dir_q  <= merged;
                    OFF_IE:   ie_q   <= merged;
                    OFF_EDGE: edge_q <= merged;
                    OFF_SET:  out_q  <= out_q | wbits;
                    OFF_CLR:  out_q  <= out_q & ~wbits;
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        rsel  = '0;
        rdata = '0;
        case (offset)
            OFF_OUT:    rsel = out_q;
            OFF_DIR:    rsel = dir_q;
            OFF_IN:     rsel = in_q;
            OFF_IE:     rsel = ie_q;
            OFF_EDGE:   rsel = edge_q;
            OFF_STATUS: rsel = status_q;
            default:    rsel = '0;
        endcase
        if (hit && memread) begin
            rdata[WIDTH-1:0] = rsel;
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = |(status_q & ie_q);

endmodule

// File: tb/tb_gpio_bank.sv
// tb/tb_gpio_bank.sv - scoreboard bench for gpio_bank (32-pin and 8-pin instances)
module tb_gpio_bank;

    localparam logic [31:0] BASE = 32'h0000_0400;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic        memwrite_a, memread_a, memwrite_b, memread_b;
    logic [31:0] rdata_a, rdata_b;
    logic        hit_a, hit_b, irq_a, irq_b;
    logic [31:0] gpio_in_a, gpio_out_a, gpio_oe_a;
    logic [7:0]  gpio_in_b, gpio_out_b, gpio_oe_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          which;
        logic [31:0] rd;
        logic        hit;
        logic        irq;
        logic [31:0] gout;
        logic [31:0] goe;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_out[2];
    logic [31:0] exp_oe[2];

    always #5 clock = ~clock;

    gpio_bank #(.BASE_ADDR(BASE), .WIDTH(32), .SYNC_STAGES(2)) u_a (
        .clock(clock), .reset(reset), .address(address), .wdata(wdata),
        .byte_en(byte_en), .memwrite(memwrite_a), .memread(memread_a),
        .rdata(rdata_a), .hit(hit_a), .gpio_in(gpio_in_a),
        .gpio_out(gpio_out_a), .gpio_oe(gpio_oe_a), .irq(irq_a)
    );

    gpio_bank #(.BASE_ADDR(BASE), .WIDTH(8), .SYNC_STAGES(2)) u_b (
        .clock(clock), .reset(reset), .address(address), .wdata(wdata),
        .byte_en(byte_en), .memwrite(memwrite_b), .memread(memread_b),
        .rdata(rdata_b), .hit(hit_b), .gpio_in(gpio_in_b),
        .gpio_out(gpio_out_b), .gpio_oe(gpio_oe_b), .irq(irq_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every read strobe is a DUT response; pop and compare.
    always @(negedge clock) begin
        if (memread_a || memread_b) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: read with no expected entry");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.which == 0) begin
                    chk({e.name, ".rdata"}, rdata_a, e.rd);
                    chk({e.name, ".hit"}, {31'b0, hit_a}, {31'b0, e.hit});
                    chk({e.name, ".irq"}, {31'b0, irq_a}, {31'b0, e.irq});
                    chk({e.name, ".gpio_out"}, gpio_out_a, e.gout);
                    chk({e.name, ".gpio_oe"}, gpio_oe_a, e.goe);
                end else begin
                    chk({e.name, ".rdata"}, rdata_b, e.rd);
                    chk({e.name, ".hit"}, {31'b0, hit_b}, {31'b0, e.hit});
                    chk({e.name, ".irq"}, {31'b0, irq_b}, {31'b0, e.irq});
                    chk({e.name, ".gpio_out"}, {24'b0, gpio_out_b}, e.gout);
                    chk({e.name, ".gpio_oe"}, {24'b0, gpio_oe_b}, e.goe);
                end
            end
        end
    end

    task automatic idle();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int which, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        address = a;
        wdata   = d;
        byte_en = be;
        if (which == 0) memwrite_a = 1'b1; else memwrite_b = 1'b1;
        idle();
        memwrite_a = 1'b0;
        memwrite_b = 1'b0;
        byte_en    = 4'b0;
    endtask

    task automatic rd(input int which, input logic [31:0] a, input logic [31:0] exp_rd,
                      input logic exp_hit, input logic exp_irq, input string nm);
        exp_t e;
        e.name  = nm;
        e.which = which;
        e.rd    = exp_rd;
        e.hit   = exp_hit;
        e.irq   = exp_irq;
        e.gout  = exp_out[which];
        e.goe   = exp_oe[which];
        sb.push_back(e);
        address = a;
        if (which == 0) memread_a = 1'b1; else memread_b = 1'b1;
        idle();
        memread_a = 1'b0;
        memread_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        address = '0; wdata = '0; byte_en = '0;
        memwrite_a = 0; memread_a = 0; memwrite_b = 0; memread_b = 0;
        gpio_in_a = '0; gpio_in_b = '0;
        exp_out[0] = '0; exp_oe[0] = '0; exp_out[1] = '0; exp_oe[1] = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        rd(0, BASE + 32'h00, 32'h0, 1'b1, 1'b0, "reset_out");
        rd(0, BASE + 32'h14, 32'h0, 1'b1, 1'b0, "reset_status");

        // Full-word writes and readback.
        wr(0, BASE + 32'h00, 32'hA5A5_A5A5, 4'b1111);
        wr(0, BASE + 32'h04, 32'hFFFF_0000, 4'b1111);
        exp_out[0] = 32'hA5A5_A5A5; exp_oe[0] = 32'hFFFF_0000;
        rd(0, BASE + 32'h00, 32'hA5A5_A5A5, 1'b1, 1'b0, "t1_out");
        rd(0, BASE + 32'h07, 32'hFFFF_0000, 1'b1, 1'b0, "t1_dir_lowbits");

        // Byte-lane write, atomic set and clear.
        wr(0, BASE + 32'h00, 32'h0012_0000, 4'b0100);
        exp_out[0] = 32'hA512_A5A5;
        rd(0, BASE + 32'h00, 32'hA512_A5A5, 1'b1, 1'b0, "t2_byte");
        wr(0, BASE + 32'h18, 32'h0000_000F, 4'b1111);
        exp_out[0] = 32'hA512_A5AF;
        rd(0, BASE + 32'h00, 32'hA512_A5AF, 1'b1, 1'b0, "t2_set");
        wr(0, BASE + 32'h1C, 32'hA000_0000, 4'b1111);
        exp_out[0] = 32'h0512_A5AF;
        rd(0, BASE + 32'h00, 32'h0512_A5AF, 1'b1, 1'b0, "t2_clr");
        rd(0, BASE + 32'h18, 32'h0, 1'b1, 1'b0, "t2_set_reads0");
        wr(0, BASE + 32'h08, 32'hFFFF_FFFF, 4'b1111);
        rd(0, BASE + 32'h08, 32'h0, 1'b1, 1'b0, "t2_in_ro");

        // Rising edge on pin 0: IN after edge 2, STATUS/irq after edge 3.
        wr(0, BASE + 32'h0C, 32'h1, 4'b1111);
        wr(0, BASE + 32'h10, 32'h0, 4'b1111);
        gpio_in_a = 32'h1;
        rd(0, BASE + 32'h08, 32'h0, 1'b1, 1'b0, "t3_in_e0");
        rd(0, BASE + 32'h08, 32'h0, 1'b1, 1'b0, "t3_in_e1");
        rd(0, BASE + 32'h08, 32'h1, 1'b1, 1'b0, "t3_in_e2");
        rd(0, BASE + 32'h14, 32'h1, 1'b1, 1'b1, "t3_status_e3");
        wr(0, BASE + 32'h14, 32'h1, 4'b1111);
        rd(0, BASE + 32'h14, 32'h0, 1'b1, 1'b0, "t3_w1c");

        // Falling edge on pin 1 coincides with its W1C: set wins.
        gpio_in_a = 32'h3;
        repeat (4) idle();
        wr(0, BASE + 32'h0C, 32'h2, 4'b1111);
        wr(0, BASE + 32'h10, 32'h2, 4'b1111);
        rd(0, BASE + 32'h14, 32'h0, 1'b1, 1'b0, "t4_pre");
        gpio_in_a = 32'h1;
        idle();
        idle();
        wr(0, BASE + 32'h14, 32'h2, 4'b1111);
        rd(0, BASE + 32'h14, 32'h2, 1'b1, 1'b1, "t4_set_wins");
        wr(0, BASE + 32'h0C, 32'h0, 4'b1111);
        rd(0, BASE + 32'h14, 32'h2, 1'b1, 1'b0, "t4_ie_mask");
        wr(0, BASE + 32'h0C, 32'h2, 4'b1111);
        rd(0, BASE + 32'h14, 32'h2, 1'b1, 1'b1, "t4_ie_restore");

        // 8-pin instance: upper bits not stored; outside window is inert.
        wr(1, BASE + 32'h00, 32'hFFFF_FFFF, 4'b1111);
        exp_out[1] = 32'h0000_00FF;
        rd(1, BASE + 32'h00, 32'h0000_00FF, 1'b1, 1'b0, "t5_width8");
        wr(1, BASE + 32'h20, 32'h0, 4'b1111);
        rd(1, BASE + 32'h20, 32'h0, 1'b0, 1'b0, "t5_outside");
        rd(1, BASE + 32'h00, 32'h0000_00FF, 1'b1, 1'b0, "t5_unchanged");

        // Reset concurrent with a write wins; pin 0 high afterwards makes no event.
        reset = 1'b1;
        wr(0, BASE + 32'h18, 32'hFFFF_FFFF, 4'b1111);
        reset = 1'b0;
        exp_out[0] = '0; exp_oe[0] = '0; exp_out[1] = '0;
        rd(0, BASE + 32'h00, 32'h0, 1'b1, 1'b0, "t6_out");
        rd(0, BASE + 32'h14, 32'h0, 1'b1, 1'b0, "t6_status");
        rd(0, BASE + 32'h0C, 32'h0, 1'b1, 1'b0, "t6_ie");
        wr(0, BASE + 32'h0C, 32'h1, 4'b1111);
        idle();
        rd(0, BASE + 32'h14, 32'h0, 1'b1, 1'b0, "t6_no_spurious");
        rd(0, BASE + 32'h08, 32'h1, 1'b1, 1'b0, "t6_in_tracks");
        rd(1, BASE + 32'h00, 32'h0, 1'b1, 1'b0, "t6_width8_reset");

        idle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
